// File: rtl/chip_despreader.sv
// Chip despreader for the O-QPSK receive chain.
// Takes the recovered serial chip stream from the CDR. It locks onto the
// 802.15.4 preamble and the SFD (0xA7). Each 32-chip PN word is reduced to a
// 4-bit symbol by minimum Hamming distance. Payload symbols go to the output
// FIFO as write strobes.
//
// Strobe semantics: i_flag qualifies exactly one chip per high cycle, and
// consecutive high cycles are legal. o_flag is a one-cycle write strobe for
// o_data. There is no ready/backpressure path in either direction, so every
// strobe is consumed in the cycle it is presented.
module chip_despreader #(
    parameter int DATA_WIDTH   = 4,
    parameter int THRESH       = 6,
    parameter int PREAMBLE_MIN = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_data,
    input  logic                  i_flag,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_flag,
    output logic                  o_sfd,
    output logic                  o_eof,
    output logic                  o_locked,
    output logic [5:0]            o_dist,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        S_SEARCH   = 2'd0,
        S_PREAMBLE = 2'd1,
        S_SFD_HI   = 2'd2,
        S_PAYLOAD  = 2'd3
    } state_t;

    localparam logic [5:0] THRESH_W  = 6'(THRESH);
    localparam logic [3:0] PRE_MIN_W = 4'(PREAMBLE_MIN);

    // PN word k with the first chip at the MSB. Words 1..7 are nibble
    // rotations of word 0, and words 8..15 invert every odd chip.
    function automatic logic [31:0] pn_word(input logic [3:0] k);
        logic [63:0] dbl;
        logic [63:0] rot;
        dbl = {32'hD9C3522E, 32'hD9C3522E};
        rot = dbl >> {k[2:0], 2'b00};
        return rot[31:0] ^ (k[3] ? 32'h55555555 : 32'h00000000);
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    state_t                state_q, state_d;
    logic [31:0]           sr_q, sr_d;
    logic [4:0]            chip_cnt_q, chip_cnt_d;
    logic [3:0]            pre_cnt_q, pre_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [5:0]            dist_q, dist_d;
    logic                  flag_q, flag_d;
    logic                  sfd_q, sfd_d;
    logic                  eof_q, eof_d;
    logic                  locked_q, locked_d;

    logic [5:0]            dist_k [16];
    logic [5:0]            min_dist;
    logic [3:0]            min_sym;
    logic                  dec_ok;
    logic                  word_end;

    // Shift in the current chip so decisions see the word including it.
    always_comb begin
        sr_d = i_flag ? {sr_q[30:0], i_data} : sr_q;
    end

    // Hamming distance of the updated window to every PN word.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            dist_k[k] = popcount32(sr_d ^ pn_word(4'(k)));
        end
    end

    // Minimum-distance symbol; strict compare keeps the lowest index on ties.
    always_comb begin
        min_dist = dist_k[0];
        min_sym  = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (dist_k[k] < min_dist) begin
                min_dist = dist_k[k];
                min_sym  = 4'(k);
            end
        end
        dec_ok   = (min_dist <= THRESH_W);
        word_end = i_flag && (chip_cnt_q == 5'd31);
    end

    // Framing FSM: next state, counters and one-cycle output pulses.
    always_comb begin
        state_d    = state_q;
        chip_cnt_d = i_flag ? chip_cnt_q + 5'd1 : chip_cnt_q;
        pre_cnt_d  = pre_cnt_q;
        data_d     = data_q;
        dist_d     = dist_q;
        flag_d     = 1'b0;
        sfd_d      = 1'b0;
        eof_d      = 1'b0;
        case (state_q)
            S_SEARCH: begin
                // Chip-by-chip sliding search for a symbol-0 word.
                chip_cnt_d = 5'd0;
                pre_cnt_d  = 4'd0;
                if (i_flag && dist_k[0] <= THRESH_W) begin
                    state_d   = S_PREAMBLE;
                    pre_cnt_d = 4'd1;
                end
            end
            S_PREAMBLE: begin
                if (word_end) begin
                    dist_d = min_dist;
                    if (dec_ok && min_sym == 4'd0) begin
                        pre_cnt_d = (pre_cnt_q == 4'd15) ? 4'd15 : pre_cnt_q + 4'd1;
                    end else if (dec_ok && min_sym == 4'd7 && pre_cnt_q >= PRE_MIN_W) begin
                        state_d = S_SFD_HI;
                    end else begin
                        state_d   = S_SEARCH;
                        pre_cnt_d = 4'd0;
                    end
                end
            end
            S_SFD_HI: begin
                if (word_end) begin
                    dist_d = min_dist;
                    if (dec_ok && min_sym == 4'hA) begin
                        state_d = S_PAYLOAD;
                        sfd_d   = 1'b1;
                    end else begin
                        state_d   = S_SEARCH;
                        pre_cnt_d = 4'd0;
                    end
                end
            end
            S_PAYLOAD: begin
                if (word_end) begin
                    dist_d = min_dist;
                    if (dec_ok) begin
                        data_d = DATA_WIDTH'(min_sym);
                        flag_d = 1'b1;
                    end else begin
                        state_d   = S_SEARCH;
                        pre_cnt_d = 4'd0;
                        eof_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_SEARCH;
            end
        endcase
        locked_d = (state_d == S_PAYLOAD);
    end

    // State and output registers; reset returns to SEARCH with no pulses.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= S_SEARCH;
            sr_q       <= 32'd0;
            chip_cnt_q <= 5'd0;
            pre_cnt_q  <= 4'd0;
            data_q     <= '0;
            dist_q     <= 6'd0;
            flag_q     <= 1'b0;
            sfd_q      <= 1'b0;
            eof_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            chip_cnt_q <= chip_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            data_q     <= data_d;
            dist_q     <= dist_d;
            flag_q     <= flag_d;
            sfd_q      <= sfd_d;
            eof_q      <= eof_d;
            locked_q   <= locked_d;
        end
    end

    assign o_data   = data_q;
    assign o_flag   = flag_q;
    assign o_sfd    = sfd_q;
    assign o_eof    = eof_q;
    assign o_locked = locked_q;
    assign o_dist   = dist_q;
    assign o_state  = state_q;

endmodule

// File: tb/tb_chip_despreader.sv
// Directed bench for chip_despreader: framing, despreading, loss of lock,
// gapped strobes and asynchronous reset.
module tb_chip_despreader;

    localparam logic [31:0] P0 = 32'hD9C3522E;
    localparam logic [31:0] P3 = 32'h22ED9C35;
    localparam logic [31:0] P5 = 32'h3522ED9C;
    localparam logic [31:0] P7 = 32'h9C3522ED;
    localparam logic [31:0] PA = 32'h7B8C9607;
    localparam logic [31:0] PC = 32'h077B8C96;
    // P3 with its first six chips inverted: distance 6 to P3, at least 8 to the rest.
    localparam logic [31:0] P3_NOISY = 32'hDEED9C35;

    logic       clk;
    logic       rst_n;
    logic       i_data;
    logic       i_flag;
    logic [3:0] o_data;
    logic       o_flag;
    logic       o_sfd;
    logic       o_eof;
    logic       o_locked;
    logic [5:0] o_dist;
    logic [1:0] o_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int sfd_cnt      = 0;
    int flag_cnt     = 0;
    int eof_cnt      = 0;

    chip_despreader #(.DATA_WIDTH(4), .THRESH(6), .PREAMBLE_MIN(4)) dut (
        .i_clk    (clk),
        .i_rst    (rst_n),
        .i_data   (i_data),
        .i_flag   (i_flag),
        .o_data   (o_data),
        .o_flag   (o_flag),
        .o_sfd    (o_sfd),
        .o_eof    (o_eof),
        .o_locked (o_locked),
        .o_dist   (o_dist),
        .o_state  (o_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (o_sfd)  sfd_cnt++;
        if (o_flag) flag_cnt++;
        if (o_eof)  eof_cnt++;
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        i_flag = 1'b0;
        i_data = 1'b0;
        repeat (3) @(negedge clk);
        sfd_cnt  = 0;
        flag_cnt = 0;
        eof_cnt  = 0;
        rst_n    = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_chip(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            i_flag = 1'b0;
            i_data = ~b;
        end
        @(negedge clk);
        i_flag = 1'b1;
        i_data = b;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 31; i >= 0; i--) send_chip(w[i], gap);
    endtask

    // Drop the strobe one cycle after the last chip; outputs are then valid.
    task automatic finish_word();
        @(negedge clk);
        i_flag = 1'b0;
        i_data = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_header(input int n_pre, input int gap);
        for (int i = 0; i < n_pre; i++) send_word(P0, gap);
        send_word(P7, gap);
        send_word(PA, gap);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n  = 1'b0;
        i_flag = 1'b0;
        i_data = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({o_flag, o_sfd, o_eof, o_locked} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_pulses: got %b expected 0000", {o_flag, o_sfd, o_eof, o_locked});
        end
        tests_run++;
        if (o_data !== 4'h0 || o_dist !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got data=%h dist=%0d expected 0/0", o_data, o_dist);
        end
        tests_run++;
        if (o_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected 0", o_state);
        end
        do_reset();
    endtask

    task automatic test_frame(input int gap);
        do_reset();
        send_header(8, gap);
        finish_word();
        tests_run++;
        if (o_sfd !== 1'b1 || o_locked !== 1'b1 || o_dist !== 6'd0) begin
            tests_failed++;
            $display("FAIL frame_sfd gap=%0d: got sfd=%b locked=%b dist=%0d expected 1/1/0", gap, o_sfd, o_locked, o_dist);
        end
        @(negedge clk);
        tests_run++;
        if (o_sfd !== 1'b0 || o_locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_sfd_width gap=%0d: got sfd=%b locked=%b expected 0/1", gap, o_sfd, o_locked);
        end
        send_word(P3, gap);
        finish_word();
        tests_run++;
        if (o_flag !== 1'b1 || o_data !== 4'h3 || o_dist !== 6'd0) begin
            tests_failed++;
            $display("FAIL frame_sym3 gap=%0d: got flag=%b data=%h dist=%0d expected 1/3/0", gap, o_flag, o_data, o_dist);
        end
        @(negedge clk);
        tests_run++;
        if (o_flag !== 1'b0 || o_data !== 4'h3) begin
            tests_failed++;
            $display("FAIL frame_flag_width gap=%0d: got flag=%b data=%h expected 0/3", gap, o_flag, o_data);
        end
        send_word(PC, gap);
        finish_word();
        tests_run++;
        if (o_flag !== 1'b1 || o_data !== 4'hC || o_dist !== 6'd0) begin
            tests_failed++;
            $display("FAIL frame_symC gap=%0d: got flag=%b data=%h dist=%0d expected 1/c/0", gap, o_flag, o_data, o_dist);
        end
        idle(3);
        tests_run++;
        if (sfd_cnt != 1 || flag_cnt != 2 || eof_cnt != 0) begin
            tests_failed++;
            $display("FAIL frame_counts gap=%0d: got sfd=%0d flag=%0d eof=%0d expected 1/2/0", gap, sfd_cnt, flag_cnt, eof_cnt);
        end
        tests_run++;
        if (o_locked !== 1'b1 || o_state !== 2'd3) begin
            tests_failed++;
            $display("FAIL frame_locked gap=%0d: got locked=%b state=%0d expected 1/3", gap, o_locked, o_state);
        end
    endtask

    task automatic test_noise_eof();
        do_reset();
        send_header(8, 0);
        send_word(P3_NOISY, 0);
        finish_word();
        tests_run++;
        if (o_flag !== 1'b1 || o_data !== 4'h3 || o_dist !== 6'd6) begin
            tests_failed++;
            $display("FAIL noise_sym: got flag=%b data=%h dist=%0d expected 1/3/6", o_flag, o_data, o_dist);
        end
        send_word(32'h0, 0);
        finish_word();
        tests_run++;
        if (o_eof !== 1'b1 || o_flag !== 1'b0 || o_locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL eof_pulse: got eof=%b flag=%b locked=%b expected 1/0/0", o_eof, o_flag, o_locked);
        end
        tests_run++;
        if (o_dist !== 6'd16 || o_data !== 4'h3 || o_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL eof_state: got dist=%0d data=%h state=%0d expected 16/3/0", o_dist, o_data, o_state);
        end
        @(negedge clk);
        tests_run++;
        if (o_eof !== 1'b0) begin
            tests_failed++;
            $display("FAIL eof_width: got %b expected 0", o_eof);
        end
    endtask

    task automatic test_short_preamble();
        do_reset();
        for (int i = 0; i < 3; i++) send_word(P0, 0);
        send_word(P7, 0);
        finish_word();
        tests_run++;
        if (o_state !== 2'd0 || o_dist !== 6'd0) begin
            tests_failed++;
            $display("FAIL short_pre_state: got state=%0d dist=%0d expected 0/0", o_state, o_dist);
        end
        send_word(PA, 0);
        finish_word();
        idle(3);
        tests_run++;
        if (sfd_cnt != 0 || flag_cnt != 0 || o_locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_pre_nosfd: got sfd=%0d flag=%0d locked=%b expected 0/0/0", sfd_cnt, flag_cnt, o_locked);
        end
    endtask

    task automatic test_min_preamble();
        do_reset();
        for (int i = 0; i < 4; i++) send_word(P0, 0);
        send_word(P7, 0);
        finish_word();
        tests_run++;
        if (o_state !== 2'd2) begin
            tests_failed++;
            $display("FAIL min_pre_state: got %0d expected 2", o_state);
        end
        send_word(PA, 0);
        finish_word();
        tests_run++;
        if (o_sfd !== 1'b1 || o_locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL min_pre_sfd: got sfd=%b locked=%b expected 1/1", o_sfd, o_locked);
        end
    endtask

    task automatic test_alignment();
        logic [12:0] junk;
        junk = 13'b1011001110001;
        do_reset();
        for (int i = 12; i >= 0; i--) send_chip(junk[i], 0);
        send_header(8, 0);
        send_word(P5, 0);
        finish_word();
        tests_run++;
        if (o_flag !== 1'b1 || o_data !== 4'h5 || o_dist !== 6'd0) begin
            tests_failed++;
            $display("FAIL align_sym5: got flag=%b data=%h dist=%0d expected 1/5/0", o_flag, o_data, o_dist);
        end
        idle(3);
        tests_run++;
        if (sfd_cnt != 1 || flag_cnt != 1) begin
            tests_failed++;
            $display("FAIL align_counts: got sfd=%0d flag=%0d expected 1/1", sfd_cnt, flag_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send_header(8, 0);
        send_word(P3, 0);
        for (int i = 31; i >= 22; i--) send_chip(PC[i], 0);
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({o_flag, o_sfd, o_eof, o_locked} !== 4'b0000 || o_data !== 4'h0 || o_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got pulses=%b data=%h state=%0d expected 0000/0/0",
                     {o_flag, o_sfd, o_eof, o_locked}, o_data, o_state);
        end
        i_flag = 1'b0;
        repeat (2) @(negedge clk);
        sfd_cnt  = 0;
        flag_cnt = 0;
        eof_cnt  = 0;
        rst_n    = 1'b1;
        send_word(P3, 0);
        send_word(PC, 0);
        finish_word();
        idle(3);
        tests_run++;
        if (flag_cnt != 0 || sfd_cnt != 0 || o_locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_quiet: got flag=%0d sfd=%0d locked=%b expected 0/0/0", flag_cnt, sfd_cnt, o_locked);
        end
        send_header(8, 0);
        send_word(P3, 0);
        finish_word();
        tests_run++;
        if (o_flag !== 1'b1 || o_data !== 4'h3) begin
            tests_failed++;
            $display("FAIL post_reset_relock: got flag=%b data=%h expected 1/3", o_flag, o_data);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n  = 1'b0;
        i_flag = 1'b0;
        i_data = 1'b0;
        test_reset();
        test_frame(0);
        test_noise_eof();
        test_short_preamble();
        test_min_preamble();
        test_alignment();
        test_frame(2);
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/chip_despreader.md
Name: chip_despreader

Overview:
- Sits directly downstream of the cdr stage and directly upstream of outFIFO in the O-QPSK receive chain.
- Consumes the recovered serial chip stream (i_data, qualified by i_flag).
- Acquires 802.15.4 preamble and SFD (0xA7).
- Despreads each 32-chip PN word to a 4-bit symbol by minimum Hamming distance, and writes payload symbols to the FIFO (o_data, o_flag → inData, inWriteEnable).

Parameters:
- DATA_WIDTH, 4, symbol width; fixed by the PN table, only 4 is legal.
- THRESH, 6, maximum Hamming distance (0..32) for a valid symbol decision.
- PREAMBLE_MIN, 4, minimum consecutive symbol-0 decisions required before the SFD is accepted (1..8).

Ports:
- i_clk, input, 1, system clock (50 MHz).
- i_rst, input, 1, asynchronous active-low reset.
- i_data, input, 1, recovered chip from cdr o_data.
- i_flag, input, 1, chip strobe from cdr o_flag; one chip per cycle where high.
- o_data, output, DATA_WIDTH, decoded payload symbol.
- o_flag, output, 1, one-cycle write strobe for o_data.
- o_sfd, output, 1, one-cycle pulse when the SFD completes.
- o_eof, output, 1, one-cycle pulse on loss of lock in PAYLOAD.
- o_locked, output, 1, high while in PAYLOAD.
- o_dist, output, 6, minimum distance of the last symbol decision (0..32).

Behaviour:
- Reset (i_rst=0, async): all outputs 0, shift register sr=0, state SEARCH, chip_cnt=0, pre_cnt=0.
- Shift register: on i_flag, sr <= {sr[30:0], i_data}. The first-received chip c0 ends at sr[31]. No activity when i_flag=0.
- PN table, c0 at MSB:
  - P0 = 0xD9C3522E.
  - Pk (k=1..7) = P0 rotated right by 4k bits.
  - Pk+8 = Pk ^ 0x55555555.
  - Check values: P1 = 0xED9C3522, P7 = 0x9C3522ED, P8 = 0x8C96077B, PA = 0x7B8C9607.
- Decision: computed on the updated sr (sr including the current chip).
  - dist_k = popcount(sr ^ Pk).
  - sym = argmin dist_k; ties go to the lowest index.
  - ok = (min dist ≤ THRESH).
- Decision timing:
  - SEARCH: the decision is evaluated on every chip.
  - All other states: evaluated only when i_flag=1 and chip_cnt==31.
  - chip_cnt counts 0..31 on i_flag and wraps to 0.
- Latency: o_flag, o_sfd and o_eof assert in the cycle after the i_flag that completed the word. o_data and o_dist are registered in that same cycle and held until the next decision.
- FSM:
  - SEARCH:
    - If dist_0 ≤ THRESH: go to PREAMBLE, pre_cnt=1, chip_cnt=0.
    - Otherwise stay in SEARCH.
  - PREAMBLE, at each word boundary:
    - ok and sym=0: pre_cnt++, saturating at 15.
    - ok and sym=7 and pre_cnt ≥ PREAMBLE_MIN: go to SFD_HI.
    - Anything else: go to SEARCH, pre_cnt=0.
  - SFD_HI:
    - ok and sym=0xA: go to PAYLOAD and pulse o_sfd.
    - Anything else: go to SEARCH.
  - PAYLOAD:
    - ok: o_data=sym, pulse o_flag.
    - Not ok: go to SEARCH, pulse o_eof, no o_flag.
- o_locked = (state==PAYLOAD), registered.
- o_dist updates on every word-boundary decision outside SEARCH.
- i_flag on consecutive cycles is legal; every chip is accepted.
- No backpressure: the FIFO is sized by the system. outWriteError from the FIFO is not this block's concern.
- Reset mid-frame: immediate return to SEARCH, no pulses.

Test Plan:
- SFD after sufficient preamble: reset, then stream 8×P0, P7, PA, P3, PC (MSB first) → o_sfd pulses once after the PA word, then o_flag pulses with o_data=3 and o_data=0xC. o_dist=0 throughout. o_locked=1 from the cycle after the SFD.
- Noise tolerance and loss of lock: same stream, but with 6 chips flipped in the P3 word → o_data=3 and o_dist=6. Then a word of all zeros (dist ≥ 16) → o_eof pulses, o_flag stays low, o_locked=0.
- Short preamble: 3×P0, then P7, PA → no o_sfd. FSM returns to SEARCH after P7, because pre_cnt=3 < 4.
- Chip-level alignment: 13 random chips, then 8×P0, P7, PA, P5 → SEARCH locks at the P0 boundary. o_data=5 is output with the correct alignment.
- Gapped strobes: same frame with i_flag asserted only every 3rd cycle → identical outputs. Each pulse is exactly 1 cycle long, one cycle after the completing strobe.
- Asynchronous reset: assert i_rst=0 mid-payload, asynchronously to the clock → all outputs 0 immediately. After release, no o_flag until a fresh preamble and SFD are received.
